// File: rtl/atm_bank_arbiter.sv
// atm_bank_arbiter: round-robin scheduler and atomic balance store for ATM terminals
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid_i / req_ready_o        per-terminal request handshake (ready is one-hot or zero)
//   req_op_i, req_src_i, req_dst_i,
//   req_amount_i                     per-terminal packed request fields
//   rsp_valid_o                      one-cycle one-hot response strobe to the served terminal
//   rsp_status_o, rsp_balance_o      result of the last operation, held until the next response
//   busy_o                           high while an operation is in flight
module atm_bank_arbiter #(
    parameter int NUM_TERM = 4,
    parameter int NUM_ACC  = 10,
    parameter int ACC_W    = 4,
    parameter int BAL_W    = 16,
    parameter int AMT_W    = 11,
    parameter int INIT_BAL = 500,
    parameter int MAX_BAL  = 2047
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_TERM-1:0]       req_valid_i,
    output logic [NUM_TERM-1:0]       req_ready_o,
    input  logic [2*NUM_TERM-1:0]     req_op_i,
    input  logic [ACC_W*NUM_TERM-1:0] req_src_i,
    input  logic [ACC_W*NUM_TERM-1:0] req_dst_i,
    input  logic [AMT_W*NUM_TERM-1:0] req_amount_i,
    output logic [NUM_TERM-1:0]       rsp_valid_o,
    output logic [1:0]                rsp_status_o,
    output logic [BAL_W-1:0]          rsp_balance_o,
    output logic                      busy_o
);
    localparam int TW = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, COMMIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [BAL_W-1:0] bal_q [NUM_ACC];
    logic [TW-1:0]    ptr_q, win_q, win;
    logic             found, hs;
    logic [1:0]       op_q, st_q, st_d;
    logic [ACC_W-1:0] src_q, dst_q;
    logic [AMT_W-1:0] amt_q;
    logic             src_ok, dst_ok;
    logic [BAL_W-1:0] src_bal, dst_bal, new_src, new_dst;
    logic [BAL_W:0]   dst_sum;

    // Descending scan so the lowest offset from the pointer is the last to win.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int i = NUM_TERM - 1; i >= 0; i--) begin
            if (req_valid_i[(int'(ptr_q) + i) % NUM_TERM]) begin
                win   = TW'((int'(ptr_q) + i) % NUM_TERM);
                found = 1'b1;
            end
        end
    end

    assign hs          = found && (state_q == IDLE) && !rst;
    assign req_ready_o = hs ? (NUM_TERM'(1) << win) : '0;
    assign rsp_valid_o = (state_q == RESP) ? (NUM_TERM'(1) << win_q) : '0;
    assign busy_o      = (state_q != IDLE);

    // Out-of-range indices read as zero so a bad source reports balance 0.
    assign src_ok  = int'(src_q) < NUM_ACC;
    assign dst_ok  = int'(dst_q) < NUM_ACC;
    assign src_bal = src_ok ? bal_q[src_q] : '0;
    assign dst_bal = dst_ok ? bal_q[dst_q] : '0;
    assign new_src = src_bal - BAL_W'(amt_q);
    assign new_dst = dst_bal + BAL_W'(amt_q);
    assign dst_sum = {1'b0, dst_bal} + (BAL_W+1)'(amt_q);

    always_comb begin
        st_d = (!src_ok || op_q == 2'b11 || (op_q == 2'b10 && (!dst_ok || dst_q == src_q))) ? 2'b10 :
               (op_q != 2'b00 && (BAL_W+1)'(amt_q) > {1'b0, src_bal})                      ? 2'b01 :
               (op_q == 2'b10 && dst_sum > (BAL_W+1)'(MAX_BAL))                            ? 2'b11 :
                                                                                             2'b00;
        state_d = (state_q == IDLE)   ? (hs ? EXEC : IDLE) :
                  (state_q == EXEC)   ? COMMIT :
                  (state_q == COMMIT) ? RESP : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ACC; a++) bal_q[a] <= BAL_W'(INIT_BAL);
            ptr_q         <= '0;
            win_q         <= '0;
            op_q          <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            amt_q         <= '0;
            st_q          <= '0;
            rsp_status_o  <= '0;
            rsp_balance_o <= '0;
        end else begin
            if (hs) begin
                win_q <= win;
                ptr_q <= (win == TW'(NUM_TERM - 1)) ? '0 : win + 1'b1;
                op_q  <= req_op_i[win*2 +: 2];
                src_q <= req_src_i[win*ACC_W +: ACC_W];
                dst_q <= req_dst_i[win*ACC_W +: ACC_W];
                amt_q <= req_amount_i[win*AMT_W +: AMT_W];
            end
            if (state_q == EXEC) st_q <= st_d;
            if (state_q == COMMIT) begin
                // Status 00 with a non-enquiry op implies valid, distinct indices.
                if (st_q == 2'b00 && op_q != 2'b00) begin
                    bal_q[src_q] <= new_src;
                    if (op_q == 2'b10) bal_q[dst_q] <= new_dst;
                end
                rsp_status_o  <= st_q;
                rsp_balance_o <= (st_q == 2'b00 && op_q != 2'b00) ? new_src : src_bal;
            end
        end
    end
endmodule

// File: tb/tb_atm_bank_arbiter.sv
// tb_atm_bank_arbiter: self-checking bench for atm_bank_arbiter against a balance model
module tb_atm_bank_arbiter;
    localparam int NT = 4, NA = 10, AW = 4, BW = 16, MW = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NT-1:0]   req_valid = '0, req_ready, rsp_valid;
    logic [2*NT-1:0] req_op = '0;
    logic [AW*NT-1:0] req_src = '0, req_dst = '0;
    logic [MW*NT-1:0] req_amount = '0;
    logic [1:0]      rsp_status;
    logic [BW-1:0]   rsp_balance;
    logic            busy;

    int tests = 0, fails = 0;
    int mbal [NA];

    // t, op, src, dst, amount, expected status, expected balance
    int plan [17][7] = '{
        '{0, 0,  2, 0,    0, 0,  500},
        '{1, 1,  4, 0,  600, 1,  500},
        '{1, 1,  4, 0,  200, 0,  300},
        '{2, 2,  0, 1,  500, 0,    0},
        '{2, 2,  0, 1,  500, 1,    0},
        '{3, 2,  6, 3,  500, 0,    0},
        '{3, 2,  1, 3, 1100, 1, 1000},
        '{0, 2,  3, 1, 1000, 0,    0},
        '{1, 2,  7, 1,  100, 3,  500},
        '{1, 2,  7, 1,   47, 0,  453},
        '{2, 0,  1, 0,    0, 0, 2047},
        '{0, 0, 12, 0,    0, 2,    0},
        '{1, 3,  2, 0,    0, 2,  500},
        '{2, 2,  5, 5,   10, 2,  500},
        '{3, 2,  5, 11,  10, 2,  500},
        '{0, 1,  8, 0,    0, 0,  500},
        '{0, 1,  8, 0,  500, 0,    0}
    };

    atm_bank_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_src_i(req_src), .req_dst_i(req_dst), .req_amount_i(req_amount),
        .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_balance_o(rsp_balance),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Apply one operation to the model following the ordered checks.
    function automatic void ref_op(input int op, input int src, input int dst, input int amt,
                                   output int st, output int bal);
        int sb, db;
        sb = (src < NA) ? mbal[src] : 0;
        db = (dst < NA) ? mbal[dst] : 0;
        if (src >= NA || op == 3 || (op == 2 && (dst >= NA || dst == src))) st = 2;
        else if (op != 0 && amt > sb) st = 1;
        else if (op == 2 && db + amt > 2047) st = 3;
        else st = 0;
        bal = sb;
        if (st == 0 && op != 0) begin
            mbal[src] = sb - amt;
            bal = sb - amt;
            if (op == 2) mbal[dst] = db + amt;
        end
    endfunction

    task automatic set_fields(input int t, input int op, input int src, input int dst, input int amt);
        req_op[t*2 +: 2]       = 2'(op);
        req_src[t*AW +: AW]    = AW'(src);
        req_dst[t*AW +: AW]    = AW'(dst);
        req_amount[t*MW +: MW] = MW'(amt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < NA; a++) mbal[a] = 500;
    endtask

    // Issue one request and report the response plus cycles from handshake to rsp_valid.
    task automatic run_op(input int t, input int op, input int src, input int dst, input int amt,
                          output int st, output int bal, output int lat, output logic [NT-1:0] rv);
        bit got = 0;
        st = -1; bal = -1; lat = -1; rv = '0;
        @(negedge clk);
        set_fields(t, op, src, dst, amt);
        req_valid[t] = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (req_ready[t]) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            req_valid[t] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[t] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                lat = i; rv = rsp_valid; st = int'(rsp_status); bal = int'(rsp_balance);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        tests++;
        if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++;
        if (rsp_status !== 2'b00 || rsp_balance !== '0) begin
            fails++; $display("FAIL reset_rsp: status %b bal %0d want 00 / 0", rsp_status, rsp_balance);
        end
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < NA; a++) mbal[a] = 500;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            fails++; $display("FAIL post_reset_idle: busy %b ready %b want 0 / 0000", busy, req_ready);
        end
    endtask

    task automatic test_plan();
        int st, bal, lat, est, ebal;
        logic [NT-1:0] rv;
        for (int k = 0; k < 17; k++) begin
            run_op(plan[k][0], plan[k][1], plan[k][2], plan[k][3], plan[k][4], st, bal, lat, rv);
            ref_op(plan[k][1], plan[k][2], plan[k][3], plan[k][4], est, ebal);
            tests++;
            if (st !== plan[k][5] || bal !== plan[k][6] || lat !== 3 || rv !== NT'(1 << plan[k][0])) begin
                fails++;
                $display("FAIL plan_%0d: status %0d bal %0d lat %0d rv %b, want status %0d bal %0d lat 3 rv %b",
                         k, st, bal, lat, rv, plan[k][5], plan[k][6], NT'(1 << plan[k][0]));
            end
        end
    endtask

    task automatic test_random();
        int st, bal, lat, est, ebal, t, op, src, dst, amt;
        logic [NT-1:0] rv;
        for (int k = 0; k < 40; k++) begin
            t   = $urandom_range(0, NT-1);
            op  = $urandom_range(0, 3);
            src = $urandom_range(0, 11);
            dst = $urandom_range(0, 11);
            amt = $urandom_range(0, 1) ? $urandom_range(0, 400) : $urandom_range(0, 2047);
            run_op(t, op, src, dst, amt, st, bal, lat, rv);
            ref_op(op, src, dst, amt, est, ebal);
            tests++;
            if (st !== est || bal !== ebal || lat !== 3 || rv !== NT'(1 << t)) begin
                fails++;
                $display("FAIL random_%0d op%0d %0d->%0d amt %0d: status %0d bal %0d lat %0d rv %b, want %0d %0d 3 %b",
                         k, op, src, dst, amt, st, bal, lat, rv, est, ebal, NT'(1 << t));
            end
        end
        for (int a = 0; a < NA; a++) begin
            run_op(a % NT, 0, a, 0, 0, st, bal, lat, rv);
            tests++;
            if (st !== 0 || bal !== mbal[a]) begin
                fails++; $display("FAIL sweep_acc%0d: status %0d bal %0d want 0 %0d", a, st, bal, mbal[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int amts [NT];
        int hs_t [$], hs_c [$], rs_t [$], rs_s [$], rs_b [$];
        int tt, est, ebal;
        bit t0_again = 0;
        do_reset();
        @(negedge clk);
        for (int t = 0; t < NT; t++) begin
            amts[t] = $urandom_range(0, 300);
            set_fields(t, 1, t, 0, amts[t]);
        end
        req_valid = '1;
        #1;
        for (int c = 0; c < 40; c++) begin
            tt = -1;
            if (rsp_valid != '0) begin
                for (int t = 0; t < NT; t++) if (rsp_valid[t]) rs_t.push_back(t);
                rs_s.push_back(int'(rsp_status));
                rs_b.push_back(int'(rsp_balance));
            end
            for (int t = 0; t < NT; t++) if (req_valid[t] && req_ready[t]) tt = t;
            if (tt >= 0) begin hs_t.push_back(tt); hs_c.push_back(c); end
            @(posedge clk);
            #1;
            if (tt > 0 || (tt == 0 && t0_again)) req_valid[tt] = 1'b0;
            if (tt == 0) t0_again = 1;
            @(negedge clk);
        end
        req_valid = '0;
        tests++;
        if (hs_t.size() != 5) begin fails++; $display("FAIL b2b_handshakes: got %0d want 5", hs_t.size()); end
        tests++;
        if (rs_t.size() != 5) begin fails++; $display("FAIL b2b_responses: got %0d want 5", rs_t.size()); end
        for (int i = 0; i < 5 && i < hs_t.size(); i++) begin
            tests++;
            if (hs_t[i] != exp_order[i]) begin
                fails++; $display("FAIL b2b_order_%0d: got T%0d want T%0d", i, hs_t[i], exp_order[i]);
            end
            if (i > 0) begin
                tests++;
                if (hs_c[i] - hs_c[i-1] != 4) begin
                    fails++; $display("FAIL b2b_gap_%0d: got %0d cycles want 4", i, hs_c[i] - hs_c[i-1]);
                end
            end
        end
        for (int i = 0; i < 5 && i < rs_t.size(); i++) begin
            ref_op(1, exp_order[i], 0, amts[exp_order[i]], est, ebal);
            tests++;
            if (rs_t[i] != exp_order[i] || rs_s[i] != est || rs_b[i] != ebal) begin
                fails++;
                $display("FAIL b2b_rsp_%0d: T%0d status %0d bal %0d want T%0d %0d %0d",
                         i, rs_t[i], rs_s[i], rs_b[i], exp_order[i], est, ebal);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int st, bal, lat;
        logic [NT-1:0] rv;
        bit got = 0, seen = 0;
        @(negedge clk);
        set_fields(2, 1, 5, 0, 100);
        req_valid[2] = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (req_ready[2]) begin got = 1; break; end
            @(negedge clk);
        end
        tests++;
        if (!got) begin fails++; $display("FAIL midrst_handshake: ready never seen, want 1"); end
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_commit: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1;
        end
        tests++;
        if (seen) begin fails++; $display("FAIL midrst_rsp_valid: got a response want none"); end
        for (int a = 0; a < NA; a++) mbal[a] = 500;
        run_op(1, 0, 5, 0, 0, st, bal, lat, rv);
        tests++;
        if (st !== 0 || bal !== 500 || lat !== 3 || rv !== 4'b0010) begin
            fails++; $display("FAIL midrst_enquiry: status %0d bal %0d lat %0d rv %b want 0 500 3 0010", st, bal, lat, rv);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
